// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: fixed-latency busy countdown, then HI/LO commit.
// Define MDU_MADD_EN to enable op 110 (madd, signed multiply-accumulate into {HI,LO}).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          accept, commit, mt_hi, mt_lo, is_mul_op, is_div_op;

  // Handshake: start is a one-cycle request sampled only in IDLE; busy high means
  // any start is dropped. There is no back-pressure beyond busy.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    commit     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mul_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
`else
    is_mul_op  = (op == OP_MULT) || (op == OP_MULTU);
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (is_mul_op) begin
            accept     = 1'b1;
            count_next = CW'(MULT_CYCLES - 1);
            state_next = RUN;
          end else if (is_div_op) begin
            accept     = 1'b1;
            count_next = CW'(DIV_CYCLES - 1);
            state_next = RUN;
          end else if (op == OP_MTHI) begin
            mt_hi = 1'b1;
          end else if (op == OP_MTLO) begin
            mt_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result datapath on the latched operands; division works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 with remainder 0.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, res_we;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem, res_hi, res_lo;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = (op_q == OP_DIV) && a_q[31];
    b_neg  = (op_q == OP_DIV) && b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    res_we = 1'b0;
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_we = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV, OP_DIVU: begin
        res_we = (b_q != 32'd0);
        res_hi = rem;
        res_lo = quot;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res_we = 1'b1; {res_hi, res_lo} = {HI, LO} + prod_s; end
`endif
      default:  res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
      end
      if (mt_hi) HI <= A;
      if (mt_lo) LO <= A;
      if (commit && res_we) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end
  end

  assign busy = (state == RUN);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .HI(hi), .LO(lo)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted request, from the ISA rules.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int lat);
    longint          sx, sy, p, q, r;
    longint unsigned ux, uy, up, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    lat = 0;
    case (o)
      3'd0: begin lat = MULT_CYCLES; p = sx * sy; {mdl_hi, mdl_lo} = p; end
      3'd1: begin lat = MULT_CYCLES; up = ux * uy; {mdl_hi, mdl_lo} = up; end
      3'd2: begin
        lat = DIV_CYCLES;
        if (y != 0) begin q = sx / sy; r = sx % sy; mdl_lo = q[31:0]; mdl_hi = r[31:0]; end
      end
      3'd3: begin
        lat = DIV_CYCLES;
        if (y != 0) begin up = ux / uy; acc = ux % uy; mdl_lo = up[31:0]; mdl_hi = acc[31:0]; end
      end
      3'd4: mdl_hi = x;
      3'd5: mdl_lo = x;
`ifdef MDU_MADD_EN
      3'd6: begin
        lat = MULT_CYCLES;
        acc = {mdl_hi, mdl_lo} + longint'(sx * sy);
        {mdl_hi, mdl_lo} = acc;
      end
`endif
      default: lat = 0;
    endcase
  endtask

  // Issue one request; optionally raise an illegal start at busy cycle 'poke'.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke);
    int lat, n;
    ref_model(o, x, y, lat);
    exp_q.push_back({mdl_hi, mdl_lo});
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == poke) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("busy_len op%0d", o), 64'(n), 64'(lat));
    check($sformatf("hilo op%0d", o), {hi, lo}, exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // Directed cases
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu_exact", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd4, 32'h11, 32'd0, 0);
    do_op(3'd5, 32'h22, 32'd0, 0);
    do_op(3'd3, 32'h1234, 32'd0, 0);
    check("divu_by0", {hi, lo}, 64'h0000_0011_0000_0022);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(3'd2, 32'd100, 32'd7, 3);
    check("div_ignore_start", {hi, lo}, 64'h0000_0002_0000_000E);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd5, 0);

    // madd: accumulates with the macro, no effect without it
    do_op(3'd4, 32'd0, 32'd0, 0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(3'd6, 32'd1, 32'd1, 0);
`ifdef MDU_MADD_EN
    check("madd_exact", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    check("madd_off", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    // Reset in the middle of a divide discards it
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    check("rst_no_late_commit", {hi, lo}, 64'd0);

    // Reset wins over a simultaneous mthi
    reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_beats_start", {busy, hi, lo}, 65'd0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      int          pk;
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      pk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      do_op(o, x, y, pk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the P6 pipeline, placed in the E stage.
- Accepts one mult/multu/div/divu/mthi/mtlo (and optionally madd) operation per start pulse and latches the operands.
- Runs a fixed-latency busy countdown, then commits the results to the architectural HI/LO registers.
- Exposes busy and HI/LO to the hazard unit and the mfhi/mflo forwarding path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; op, A and B are valid while it is high.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 reserved.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  high while a mult/div operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Reset at a posedge forces state=IDLE, busy=0, HI=0, LO=0 and count=0.
  - Reset beats every other input, including a simultaneous start.
  - Reset mid-operation discards the in-flight result; HI/LO read 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, count decrements each cycle.
- IDLE with start=1 at a posedge:
  - op 000/001/110: latch A, B and op; count<=MULT_CYCLES-1; go to RUN.
  - op 010/011: latch A, B and op; count<=DIV_CYCLES-1; go to RUN.
  - op 100 (mthi): HI<=A at that edge; stay IDLE; busy stays 0.
  - op 101 (mtlo): LO<=A at that edge; stay IDLE; busy stays 0.
  - op 111: no effect.
- RUN:
  - count!=0: count<=count-1.
  - count==0: commit the result to HI/LO at that edge, busy<=0, go to IDLE.
  - Net timing: busy is high for exactly N cycles, where N is the op's latency parameter.
  - New HI/LO is visible on the first cycle busy reads 0.
- start while RUN: ignored; op, A, B, HI and LO are untouched. The hazard unit stalls D so this never occurs legally; the bench still checks it.
- A new start is accepted in the first IDLE cycle after a commit; there are no back-to-back bubble requirements.
- Arithmetic, on the latched operands:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B==0, div or divu): HI/LO unchanged at commit; busy timing is unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI and LO are registered outputs and change only at reset, at an mthi/mtlo accept, or at a commit edge.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 110 (madd) uses MULT_CYCLES latency. At commit, {HI,LO} <= {HI,LO} + signed(A)*signed(B), modulo 2^64, using the HI/LO values present at the commit edge.
- Not defined: op 110 is treated like 111 (no effect, busy stays 0), and no accumulate adder is synthesized.

Test Plan:
- Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload via mthi A=0x11 and mtlo A=0x22 (busy never rises, HI/LO update the next cycle), then divu with B=0 -> after 10 cycles HI=0x11, LO=0x22.
- During a div: start mult at busy cycle 3 (ignored, final result is the div's), and assert reset at busy cycle 6 -> next cycle busy=0, HI=LO=0, no late commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then madd A=1, B=1 -> HI=1, LO=0. Without the macro: op 110 leaves busy=0 and HI/LO unchanged.
